// File: rtl/conv_pool_writeback_pkg.sv
// Shared widths, FSM encoding and error-flag bit positions for the pool/writeback stage.
// Build option POOL_RELU_EN (see pool_max4_sat) selects ReLU clamping of pooled words.
package conv_pool_writeback_pkg;

    localparam int unsigned ACC_W_DEF  = 20;
    localparam int unsigned OUT_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned SHIFT_DEF  = 4;
    localparam int unsigned N_LANES    = 4;

    // err_flags = {addr_wrap, partial_window, lane_overrun}
    localparam int unsigned ERR_W              = 3;
    localparam int unsigned ERR_LANE_OVERRUN   = 0;
    localparam int unsigned ERR_PARTIAL_WINDOW = 1;
    localparam int unsigned ERR_ADDR_WRAP      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

endpackage

// File: rtl/conv_pool_writeback_if.sv
// Accumulator-lane input bus and output-SRAM write bus of the pool/writeback stage.
// master = controller/SRAM side, slave = conv_pool_writeback.
interface conv_pool_writeback_if
    import conv_pool_writeback_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [N_LANES-1:0]       acc_send;
    logic [N_LANES*ACC_W-1:0] acc_data;
    logic                     matrix_done_flag;
    logic                     mem_wr_en;
    logic [ADDR_W-1:0]        mem_wr_addr;
    logic [OUT_W-1:0]         mem_wr_data;

    modport master (
        output acc_send, acc_data, matrix_done_flag,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  acc_send, acc_data, matrix_done_flag,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/conv_pool_writeback_pool_max4_sat.sv
// Combinational 2x2 window max plus arithmetic shift and output clamp (pool_max4_sat).
// POOL_RELU_EN defined: lower clamp bound is 0 instead of the most negative output word.
module conv_pool_writeback_pool_max4_sat
    import conv_pool_writeback_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic [N_LANES*ACC_W-1:0] lanes_i,
    output logic signed [ACC_W-1:0]  max_o,
    input  logic signed [ACC_W-1:0]  sat_in_i,
    output logic [OUT_W-1:0]         sat_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
`ifdef POOL_RELU_EN
    localparam logic signed [ACC_W-1:0] SAT_LO = '0;
`else
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_MAX;
`endif

    logic signed [ACC_W-1:0] lane_c [N_LANES];
    logic signed [ACC_W-1:0] m01_c;
    logic signed [ACC_W-1:0] m23_c;
    logic signed [ACC_W-1:0] shifted_c;

    always_comb begin
        for (int i = 0; i < int'(N_LANES); i++) begin
            lane_c[i] = $signed(lanes_i[i*ACC_W +: ACC_W]);
        end
    end

    // Pairwise tree; ties pick either operand, which is value-identical.
    assign m01_c = (lane_c[0] > lane_c[1]) ? lane_c[0] : lane_c[1];
    assign m23_c = (lane_c[2] > lane_c[3]) ? lane_c[2] : lane_c[3];
    assign max_o = (m01_c > m23_c) ? m01_c : m23_c;

    assign shifted_c = sat_in_i >>> SHIFT;

    always_comb begin
        sat_o = OUT_W'(shifted_c);
        if (shifted_c > SAT_MAX) begin
            sat_o = OUT_W'(SAT_MAX);
        end else if (shifted_c < SAT_LO) begin
            sat_o = OUT_W'(SAT_LO);
        end
    end

endmodule

// File: rtl/conv_pool_writeback.sv
// Pool/writeback stage: captures 4 accumulator lanes per 2x2 window, max-pools, scales and
// writes one word per window to the output SRAM. Build option: POOL_RELU_EN (ReLU clamp).
module conv_pool_writeback
    import conv_pool_writeback_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned SHIFT  = SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 reset_datapath_n,
    input  logic                 load_base,
    input  logic [ADDR_W-1:0]    out_base_addr,
    conv_pool_writeback_if.slave bus,
    output logic                 pool_busy,
    output logic                 pool_done,
    output logic [ERR_W-1:0]     err_flags
);

    pool_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] cap_q [N_LANES];
    logic signed [ACC_W-1:0] cap_d [N_LANES];
    logic [N_LANES-1:0]      cap_vld_q, cap_vld_d;
    logic                    st1_vld_q, st1_vld_d;
    logic signed [ACC_W-1:0] st1_max_q, st1_max_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ERR_W-1:0]        err_q, err_d;

    logic [N_LANES*ACC_W-1:0] merged_c;
    logic [N_LANES-1:0]       hit_c;
    logic                     win_c;
    logic signed [ACC_W-1:0]  max_c;
    logic [OUT_W-1:0]         sat_c;

    // Lanes arriving this cycle override held captures, so a window can close on its last lane.
    always_comb begin
        merged_c = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            merged_c[i*ACC_W +: ACC_W] = bus.acc_send[i] ? bus.acc_data[i*ACC_W +: ACC_W]
                                                         : cap_q[i];
        end
    end

    assign hit_c = cap_vld_q | bus.acc_send;
    assign win_c = &hit_c;

    conv_pool_writeback_pool_max4_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_pool (
        .lanes_i  (merged_c),
        .max_o    (max_c),
        .sat_in_i (st1_max_q),
        .sat_o    (sat_c)
    );

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;
        st1_vld_d = 1'b0;
        st1_max_d = st1_max_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        err_d     = err_q;

        // Stage1 -> write stage runs in every state so FLUSH can drain the pipe.
        if (st1_vld_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = sat_c;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            if (&wr_ptr_q) begin
                err_d[ERR_ADDR_WRAP] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load_base) begin
                    wr_ptr_d = out_base_addr;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < int'(N_LANES); i++) begin
                    if (bus.acc_send[i]) begin
                        cap_d[i] = $signed(bus.acc_data[i*ACC_W +: ACC_W]);
                    end
                end
                if ((bus.acc_send & cap_vld_q) != '0) begin
                    err_d[ERR_LANE_OVERRUN] = 1'b1;
                end
                if (win_c) begin
                    st1_vld_d = 1'b1;
                    st1_max_d = max_c;
                    cap_vld_d = '0;
                end else begin
                    cap_vld_d = hit_c;
                end
                // A window closing in the same cycle is kept; any leftover lanes are dropped.
                if (bus.matrix_done_flag) begin
                    if (!win_c && (hit_c != '0)) begin
                        err_d[ERR_PARTIAL_WINDOW] = 1'b1;
                    end
                    cap_vld_d = '0;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!st1_vld_q && !wr_en_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
        endcase

        if (!reset_datapath_n) begin
            state_d   = ST_IDLE;
            cap_vld_d = '0;
            st1_vld_d = 1'b0;
            wr_en_d   = 1'b0;
            wr_ptr_d  = wr_ptr_q;
            err_d     = err_q;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH) || st1_vld_d || wr_en_d;
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < int'(N_LANES); i++) begin
                cap_q[i] <= '0;
            end
            cap_vld_q <= '0;
            st1_vld_q <= 1'b0;
            st1_max_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < int'(N_LANES); i++) begin
                cap_q[i] <= cap_d[i];
            end
            cap_vld_q <= cap_vld_d;
            st1_vld_q <= st1_vld_d;
            st1_max_q <= st1_max_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign pool_busy       = busy_q;
    assign pool_done       = done_q;
    assign err_flags       = err_q;

endmodule

// File: tb/tb_conv_pool_writeback.sv
// Bench for conv_pool_writeback: directed plus random windows against a window-level model
// (expected writes held in a queue keyed by the cycle they must appear).
module tb_conv_pool_writeback;
    import conv_pool_writeback_pkg::*;

    localparam int unsigned ACC_W  = 20;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned SHIFT  = 4;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              reset_datapath_n;
    logic              load_base;
    logic [ADDR_W-1:0] out_base_addr;
    logic              pool_busy;
    logic              pool_done;
    logic [2:0]        err_flags;

    always #5 clk = ~clk;

    conv_pool_writeback_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    conv_pool_writeback #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SHIFT(SHIFT)
    ) dut (
        .clk              (clk),
        .reset_b          (reset_b),
        .reset_datapath_n (reset_datapath_n),
        .load_base        (load_base),
        .out_base_addr    (out_base_addr),
        .bus              (bus),
        .pool_busy        (pool_busy),
        .pool_done        (pool_done),
        .err_flags        (err_flags)
    );

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
    } wr_t;

    wr_t               exp_q[$];
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;
    int                done_due = -100;
    int                last_due = -100;
    int                m_phase = 0;      // 0 idle, 1 accepting lanes, 2 flushing/done
    logic [ADDR_W-1:0] m_ptr = '0;
    logic [3:0]        m_vld = '0;
    int                m_lane[4];
    logic              m_wrap = 1'b0;
    logic              m_partial = 1'b0;
    logic              m_over = 1'b0;
    int                lane_v[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] pool_val(input int a, input int b, input int c, input int d);
        int mx;
        int y;
        int hi;
        int lo;
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        if (d > mx) mx = d;
        y  = mx >>> SHIFT;
        hi = (1 << (OUT_W - 1)) - 1;
`ifdef POOL_RELU_EN
        lo = 0;
`else
        lo = -(1 << (OUT_W - 1));
`endif
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return OUT_W'(y);
    endfunction

    // One clock; then check write bus, done pulse and sticky flags against the model.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (&e.addr) m_wrap = 1'b1;
            chk("wr_en", 32'(bus.mem_wr_en), 32'd1);
            chk("wr_addr", 32'(bus.mem_wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.mem_wr_data), 32'(e.data));
        end else begin
            chk("wr_idle", 32'(bus.mem_wr_en), 32'd0);
        end
        chk("pool_done", 32'(pool_done), (cyc == done_due) ? 32'd1 : 32'd0);
        if (cyc == done_due) chk("busy_in_done", 32'(pool_busy), 32'd0);
        chk("err_flags", 32'(err_flags), 32'({m_wrap, m_partial, m_over}));
        if (m_phase == 2 && cyc == done_due + 1) m_phase = 1;
    endtask

    task automatic drive(input logic [3:0] mask, input logic mdone);
        if (m_phase == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (m_vld[i]) m_over = 1'b1;
                    m_lane[i] = lane_v[i];
                    m_vld[i]  = 1'b1;
                end
            end
            if (m_vld == 4'hF) begin
                exp_q.push_back('{cyc + 2, m_ptr,
                                  pool_val(m_lane[0], m_lane[1], m_lane[2], m_lane[3])});
                last_due = cyc + 2;
                m_ptr    = ADDR_W'(m_ptr + 1);
                m_vld    = '0;
            end
            if (mdone) begin
                if (m_vld != '0) m_partial = 1'b1;
                m_vld    = '0;
                m_phase  = 2;
                done_due = (last_due + 2 > cyc + 2) ? last_due + 2 : cyc + 2;
            end
        end
        bus.acc_send = mask;
        for (int i = 0; i < 4; i++) bus.acc_data[i*ACC_W +: ACC_W] = ACC_W'(lane_v[i]);
        bus.matrix_done_flag = mdone;
        step();
        bus.acc_send         = '0;
        bus.matrix_done_flag = 1'b0;
    endtask

    task automatic set_lanes(input int a, input int b, input int c, input int d);
        lane_v[0] = a;
        lane_v[1] = b;
        lane_v[2] = c;
        lane_v[3] = d;
    endtask

    task automatic rand_lanes();
        logic [ACC_W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            r         = ACC_W'($urandom);
            lane_v[i] = int'($signed(r));
        end
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] base);
        load_base     = 1'b1;
        out_base_addr = base;
        if (m_phase == 0) begin
            m_ptr   = base;
            m_phase = 1;
        end
        step();
        load_base = 1'b0;
        chk("load_busy", 32'(pool_busy), 32'd1);
    endtask

    // Datapath clear: in-flight windows are dropped and their addresses not consumed.
    task automatic dp_clear();
        while (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            m_ptr = ADDR_W'(m_ptr - 1);
        end
        m_vld            = '0;
        m_phase          = 0;
        done_due         = -100;
        last_due         = -100;
        reset_datapath_n = 1'b0;
        step();
        reset_datapath_n = 1'b1;
        chk("dpclr_busy", 32'(pool_busy), 32'd0);
    endtask

    task automatic finish_dataset();
        for (int n = 0; n < 40; n++) begin
            if (cyc > done_due) break;
            step();
        end
    endtask

    initial begin
        reset_b              = 1'b0;
        reset_datapath_n     = 1'b1;
        load_base            = 1'b0;
        out_base_addr        = '0;
        bus.acc_send         = '0;
        bus.acc_data         = '0;
        bus.matrix_done_flag = 1'b0;
        set_lanes(0, 0, 0, 0);
        #3;
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
        chk("rst_busy", 32'(pool_busy), 32'd0);
        chk("rst_done", 32'(pool_done), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        #10 reset_b = 1'b1;

        // First window, two halves: expect 17>>>4 = 1 at 0x010 two cycles after completion.
        do_load(12'h010);
        set_lanes(5, -3, 17, 9);
        drive(4'hC, 1'b0);
        drive(4'h3, 1'b0);
        step();
        step();

        // Back-to-back full windows, one per cycle.
        for (int k = 0; k < 8; k++) begin
            rand_lanes();
            drive(4'hF, 1'b0);
        end
        step();
        step();

        // Negative, positive-extreme and most-negative windows.
        set_lanes(-40000, -40000, -40000, -40000);
        drive(4'hF, 1'b0);
        set_lanes((1 << 19) - 1, 0, -5, 3);
        drive(4'hF, 1'b0);
        set_lanes(-(1 << 19), -(1 << 19), -(1 << 19), -(1 << 19));
        drive(4'hF, 1'b0);
        step();
        step();

        // Lane 2 sent twice: second value wins and overrun is flagged.
        set_lanes(0, 0, 100, 0);
        drive(4'h4, 1'b0);
        set_lanes(0, 0, 777, 0);
        drive(4'h4, 1'b0);
        set_lanes(-20, 30, 0, 40);
        drive(4'hB, 1'b0);
        step();
        step();
        chk("overrun_set", 32'(err_flags[ERR_LANE_OVERRUN]), 32'd1);

        // Partial window at matrix_done: discarded, done two cycles later.
        rand_lanes();
        drive(4'h3, 1'b0);
        drive(4'h0, 1'b1);
        finish_dataset();
        chk("partial_set", 32'(err_flags[ERR_PARTIAL_WINDOW]), 32'd1);

        // Next dataset continues the pointer; window completing with matrix_done is kept.
        rand_lanes();
        drive(4'hF, 1'b0);
        rand_lanes();
        drive(4'hF, 1'b1);
        finish_dataset();

        // Datapath clear while stage1 holds a window: no write, then IDLE ignores lanes.
        rand_lanes();
        drive(4'hF, 1'b0);
        dp_clear();
        rand_lanes();
        drive(4'hF, 1'b0);
        step();
        step();
        chk("idle_busy", 32'(pool_busy), 32'd0);

        // Address wrap.
        do_load(12'hFFF);
        rand_lanes();
        drive(4'hF, 1'b0);
        rand_lanes();
        drive(4'hF, 1'b0);
        step();
        step();
        chk("wrap_set", 32'(err_flags[ERR_ADDR_WRAP]), 32'd1);

        // Random dataset from a random base.
        dp_clear();
        do_load(ADDR_W'($urandom));
        for (int k = 0; k < 150; k++) begin
            rand_lanes();
            drive(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 1'b0);
        end
        rand_lanes();
        drive(4'($urandom), 1'b1);
        finish_dataset();

        // Async reset in the middle of a write.
        set_lanes(1000, 2000, 3000, 4000);
        drive(4'hF, 1'b0);
        step();
        #2 reset_b = 1'b0;
        #1;
        chk("arst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("arst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        chk("arst_wr_data", 32'(bus.mem_wr_data), 32'd0);
        chk("arst_busy", 32'(pool_busy), 32'd0);
        chk("arst_done", 32'(pool_done), 32'd0);
        chk("arst_err", 32'(err_flags), 32'd0);
        exp_q.delete();
        m_ptr     = '0;
        m_vld     = '0;
        m_phase   = 0;
        m_wrap    = 1'b0;
        m_partial = 1'b0;
        m_over    = 1'b0;
        done_due  = -100;
        last_due  = -100;
        #3 reset_b = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
